// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage
//
// Generates sequential word-aligned fetch addresses and issues them to
// instruction memory. In-order responses are collected in a small FIFO of
// {pc, instr} pairs and handed to decode. A redirect flushes the FIFO and
// arranges for every response still in flight to be discarded. A misaligned
// redirect target produces a single fault entry, then the stage idles until
// the next redirect.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     FIFO entries and maximum outstanding requests (power of two, >= 2)
//
// Ports
//   i_clk              core clock, all state on rising edge
//   i_rst              synchronous active-high reset
//   o_imem_req_valid   fetch request valid
//   i_imem_req_ready   memory accepts request
//   o_imem_req_addr    word-aligned fetch address
//   i_imem_rsp_valid   response valid (in order, no backpressure)
//   i_imem_rsp_data    instruction word
//   i_redirect_valid   branch/jump/trap redirect, single-cycle pulse
//   i_redirect_pc      new fetch target
//   o_if_valid         entry available to decode
//   i_if_ready         decode accepts entry
//   o_if_pc            PC of head entry
//   o_if_instr         instruction of head entry
//   o_if_fault         head is an instruction-address-misaligned fault
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_valid,
    input  logic        i_if_ready,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    output logic        o_if_fault
);

    localparam int unsigned PW = $clog2(DEPTH);   // FIFO pointer width
    localparam int unsigned CW = PW + 1;          // counters holding 0..DEPTH
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FAULT,
        ST_HALT
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [31:0]   r_fault_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];

    logic [CW:0]   w_used;
    logic          w_credit;
    logic          w_req_fire;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_misaligned;

    // Credit counts both requests in flight and buffered entries, so every
    // response is guaranteed a free FIFO slot. A same-cycle pop earns no credit.
    assign w_used       = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_credit     = (w_used < LIMIT);

    assign o_imem_req_valid = (r_state == ST_RUN) && !i_rst && !i_redirect_valid && w_credit;
    assign o_imem_req_addr  = r_fetch_pc;

    assign w_req_fire   = o_imem_req_valid && i_imem_req_ready;
    assign w_drop       = i_imem_rsp_valid && (r_drop_cnt != '0);
    // A redirect wins over a same-cycle response push and a same-cycle pop.
    assign w_push       = i_imem_rsp_valid && (r_drop_cnt == '0) && !i_redirect_valid;
    assign w_pop        = (r_state == ST_RUN) && (r_count != '0) && i_if_ready && !i_redirect_valid;
    assign w_misaligned = (i_redirect_pc[1:0] != 2'b00);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_if_valid = 1'b0;
        o_if_fault = 1'b0;
        o_if_pc    = '0;
        o_if_instr = '0;
        case (r_state)
            ST_RUN: begin
                if (r_count != '0) begin
                    o_if_valid = 1'b1;
                    o_if_pc    = r_mem_pc[r_rd_ptr];
                    o_if_instr = r_mem_instr[r_rd_ptr];
                end
            end
            ST_FAULT: begin
                o_if_valid = 1'b1;
                o_if_fault = 1'b1;
                o_if_pc    = r_fault_pc;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_fault_pc <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            // Every response retires one in-flight request, kept or dropped.
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(i_imem_rsp_valid);

            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (i_redirect_valid) begin
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                // Everything still outstanding after this cycle belongs to the
                // old path; a response arriving this cycle is already discarded.
                r_drop_cnt <= r_inflight - CW'(i_imem_rsp_valid);
                r_fetch_pc <= i_redirect_pc;
                r_rsp_pc   <= i_redirect_pc;
                r_fault_pc <= i_redirect_pc;
                r_state    <= w_misaligned ? ST_FAULT : ST_RUN;
            end else begin
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
                if ((r_state == ST_FAULT) && i_if_ready) begin
                    r_state <= ST_HALT;
                end
            end
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only read once r_count says
    // it was written, and the outputs are zeroed whenever nothing is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
            r_mem_instr[r_wr_ptr] <= i_imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_req_addr  (imem_req_addr),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_if_valid       (if_valid),
        .i_if_ready       (if_ready),
        .o_if_pc          (if_pc),
        .o_if_instr       (if_instr),
        .o_if_fault       (if_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mrsp_t;

    exp_t        sb[$];      // entries decode must still see, in order
    mrsp_t       pend[$];    // memory responses scheduled
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] exp_fetch = RESET_PC;
    bit          no_fetch  = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]} + 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_if_valid(input string tag, input int max);
        int n = 0;
        while (if_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(if_valid), 64'(1));
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // memory: presents scheduled responses shortly after each rising edge
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // mid-cycle monitor: request scheduling and scoreboard compare
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb.delete();
            pend.delete();
            exp_fetch = RESET_PC;
            no_fetch  = 1'b0;
        end else if (redirect_valid) begin
            check("req_during_redirect", 64'(imem_req_valid), 64'(0));
            sb.delete();
            exp_fetch = redirect_pc;
            no_fetch  = (redirect_pc[1:0] != 2'b00);
            if (no_fetch) sb.push_back('{redirect_pc, 32'h0, 1'b1});
        end else begin
            if (if_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_if_valid", 64'(if_valid), 64'(0));
                end else begin
                    check("head_pc", 64'(if_pc), 64'(sb[0].pc));
                    check("head_instr", 64'(if_instr), 64'(sb[0].instr));
                    check("head_fault", 64'(if_fault), 64'(sb[0].fault));
                    if (if_ready) void'(sb.pop_front());
                end
            end
            if (no_fetch) check("no_req_fault_halt", 64'(imem_req_valid), 64'(0));
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", 64'(imem_req_addr), 64'(exp_fetch));
                pend.push_back('{cyc + lat, mem_data(imem_req_addr)});
                sb.push_back('{exp_fetch, mem_data(exp_fetch), 1'b0});
                exp_fetch = exp_fetch + 32'd4;
            end
            check("outstanding_le_depth", 64'(sb.size() <= DEPTH), 64'(1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;

        // reset state
        drive_edge();
        @(negedge clk);
        check("rst_req_valid", 64'(imem_req_valid), 64'(0));
        check("rst_if_valid", 64'(if_valid), 64'(0));
        check("rst_if_fault", 64'(if_fault), 64'(0));
        check("rst_if_pc", 64'(if_pc), 64'(0));
        check("rst_if_instr", 64'(if_instr), 64'(0));

        // first request in the first cycle out of reset, data two cycles later
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", 64'(imem_req_valid), 64'(1));
        check("first_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        n = 0;
        while (if_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_latency", 64'(n), 64'(2));
        check("first_if_pc", 64'(if_pc), 64'(RESET_PC));
        check("first_if_instr", 64'(if_instr), 64'(mem_data(RESET_PC)));

        // back-to-back streaming
        repeat (8) begin
            @(negedge clk);
            check("b2b_req_valid", 64'(imem_req_valid), 64'(1));
            check("b2b_if_valid", 64'(if_valid), 64'(1));
        end

        // decode stall: credit limit stops requests, head held
        drive_edge();
        if_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_req_dropped", 64'(imem_req_valid), 64'(0));
        check("stall_buffered", 64'(sb.size()), 64'(DEPTH));
        drive_edge();
        if_ready = 1'b1;
        repeat (10) @(negedge clk);

        // switch memory to 3-cycle latency once idle
        drive_edge();
        imem_req_ready = 1'b0;
        repeat (4) @(negedge clk);
        drive_edge();
        lat            = 3;
        imem_req_ready = 1'b1;
        repeat (8) @(negedge clk);

        // aligned redirect with responses in flight
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_if_valid", 64'(if_valid), 64'(0));
        check("redir_req_valid", 64'(imem_req_valid), 64'(1));
        check("redir_req_addr", 64'(imem_req_addr), 64'(32'h2000));
        wait_if_valid("redir_wait", 12);
        check("redir_if_pc", 64'(if_pc), 64'(32'h2000));
        check("redir_if_instr", 64'(if_instr), 64'(mem_data(32'h2000)));
        repeat (4) @(negedge clk);

        // misaligned redirect: single fault entry, then halt
        drive_edge();
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("fault_req_valid", 64'(imem_req_valid), 64'(0));
        check("fault_if_valid", 64'(if_valid), 64'(1));
        check("fault_if_fault", 64'(if_fault), 64'(1));
        check("fault_if_pc", 64'(if_pc), 64'(32'h2002));
        check("fault_if_instr", 64'(if_instr), 64'(0));
        @(negedge clk);
        check("fault_hold", 64'(if_valid), 64'(1));
        drive_edge();
        if_ready = 1'b1;
        drive_edge();
        repeat (6) begin
            @(negedge clk);
            check("halt_if_valid", 64'(if_valid), 64'(0));
            check("halt_req_valid", 64'(imem_req_valid), 64'(0));
        end

        // aligned redirect leaves halt
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("resume_req_valid", 64'(imem_req_valid), 64'(1));
        check("resume_req_addr", 64'(imem_req_addr), 64'(32'h3000));
        wait_if_valid("resume_wait", 12);
        check("resume_if_pc", 64'(if_pc), 64'(32'h3000));
        check("resume_if_fault", 64'(if_fault), 64'(0));

        // address wrap at the top of the address space
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        wait_if_valid("wrap_wait", 12);
        check("wrap_first_pc", 64'(if_pc), 64'(32'hFFFF_FFF8));
        repeat (10) @(negedge clk);

        // reset mid-stream; memory restarts with 1-cycle latency
        drive_edge();
        rst = 1'b1;
        lat = 1;
        @(negedge clk);
        check("midrst_req_valid", 64'(imem_req_valid), 64'(0));
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_if_valid", 64'(if_valid), 64'(0));
        check("midrst_if_fault", 64'(if_fault), 64'(0));
        check("midrst_if_pc", 64'(if_pc), 64'(0));
        check("midrst_if_instr", 64'(if_instr), 64'(0));
        check("midrst_req_valid_after", 64'(imem_req_valid), 64'(1));
        check("midrst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        wait_if_valid("midrst_wait", 6);
        check("midrst_first_pc", 64'(if_pc), 64'(RESET_PC));
        repeat (5) @(negedge clk);

        // redirect coinciding with a response and a pop
        drive_edge();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        @(negedge clk);
        check("sim_rsp_valid", 64'(imem_rsp_valid), 64'(1));
        check("sim_if_valid", 64'(if_valid), 64'(1));
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("sim_next_if_valid", 64'(if_valid), 64'(0));
        check("sim_req_addr", 64'(imem_req_addr), 64'(32'h4000));
        @(negedge clk);
        check("sim_gap_if_valid", 64'(if_valid), 64'(0));
        @(negedge clk);
        check("sim_deliver_valid", 64'(if_valid), 64'(1));
        check("sim_deliver_pc", 64'(if_pc), 64'(32'h4000));
        check("sim_deliver_instr", 64'(if_instr), 64'(mem_data(32'h4000)));
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V core. Generates sequential fetch addresses, issues them to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. Delivers {pc, instr} pairs to the decode stage through a valid/ready handshake. Handles control-flow redirects by flushing buffered entries and discarding stale in-flight responses. Sits between instruction memory and decode inside `core_top`.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, FIFO entries and maximum in-flight requests (power of two, ≥2)
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word-aligned fetch address
- `imem_rsp_valid`  in  1  response valid (no backpressure, in order)
- `imem_rsp_data`  in  32  instruction word
- `redirect_valid`  in  1  branch/jump/trap redirect, single-cycle pulse
- `redirect_pc`  in  32  new fetch target
- `if_valid`  out  1  entry available to decode
- `if_ready`  in  1  decode accepts entry
- `if_pc`  out  32  PC of head entry
- `if_instr`  out  32  instruction of head entry
- `if_fault`  out  1  head is an instruction-address-misaligned fault

## Operation
- State: `fetch_pc`, `rsp_pc` (PC of next kept response), `inflight` (0..DEPTH), `drop_cnt` (0..DEPTH), FIFO of {pc, instr} with `count`, FSM {RUN, FAULT, HALT}.
- Request: `imem_req_valid = (state==RUN) && !rst && !redirect_valid && (inflight + count < DEPTH)`. `imem_req_addr = fetch_pc`. On handshake: `fetch_pc += 4`, `inflight += 1`.
- Response: every `imem_rsp_valid` decrements `inflight`. If `drop_cnt > 0`, discard and decrement `drop_cnt`. Otherwise push {rsp_pc, imem_rsp_data} and `rsp_pc += 4`.
- Invariant: `inflight + count ≤ DEPTH`. A push never hits a full FIFO, so no overflow path is needed.
- Pop on `if_valid && if_ready`. Push and pop in the same cycle leave `count` unchanged.
- Redirect, aligned (`redirect_pc[1:0]==0`):
  - Flush the FIFO.
  - `drop_cnt <= inflight - imem_rsp_valid`. Same-cycle responses are discarded.
  - `fetch_pc <= rsp_pc <= redirect_pc`.
  - `state <= RUN`.
- Redirect, misaligned:
  - Flush the FIFO and set `drop_cnt` as above.
  - Enter FAULT. No requests are issued.
  - Present `if_valid=1`, `if_fault=1`, `if_pc=redirect_pc`, `if_instr=0`.
  - On handshake → HALT. HALT issues nothing and presents nothing until the next redirect.
- A redirect overrides a same-cycle pop and a same-cycle response push.
- Address arithmetic is mod 2^32; `fetch_pc` wraps from 0xFFFF_FFFC to 0.

## Timing
- Reset values:
  - `imem_req_valid=0`, `if_valid=0`, `if_fault=0`, `if_pc=0`, `if_instr=0`.
  - `fetch_pc=rsp_pc=RESET_PC`, `inflight=drop_cnt=count=0`, state RUN.
- First request with `addr=RESET_PC` in the first cycle with `rst=0`.
- Memory response latency is ≥1 cycle after request handshake.
- A pushed entry appears on `if_*` the cycle after the response (registered FIFO). Minimum request-to-`if_valid` latency is 2 cycles.
- Credit check uses registered `inflight`/`count` (no same-cycle pop credit). One fetch/cycle is sustained with DEPTH=4 and 1-cycle memory.
- The cycle after a redirect: `if_valid=0` (or fault entry valid), and the request to `redirect_pc` is issued if credit allows.
- `if_*` holds stable while `if_valid && !if_ready`.
- Reset mid-operation clears all state next edge. Responses to pre-reset requests arriving after reset are the memory's responsibility; the memory must also be reset.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory, `if_ready=1` → requests 0x100, 0x104, 0x108… back-to-back; first `if_valid` 2 cycles after first request; pcs increment by 4.
- `if_ready=0` for 10 cycles → at most DEPTH=4 requests outstanding+buffered; `imem_req_valid` drops; head {0x100, data} held; resumes in order with no loss or duplication.
- Memory latency 3, redirect to 0x2000 with 2 responses in flight → both stale responses discarded; next `if_pc=0x2000` with correct data; FIFO contents before redirect never reach decode.
- Redirect to 0x2002 → no further requests; `if_valid=1`, `if_fault=1`, `if_pc=0x2002`; after handshake `if_valid=0`; aligned redirect to 0x3000 resumes fetching.
- `rst` asserted for 1 cycle mid-stream → next cycle all outputs at reset values; then fetch restarts at RESET_PC.
- Simultaneous redirect, response and pop in one cycle → response dropped, no pop side-effects, `drop_cnt=inflight-1`; next delivered pc = redirect target.
